// File: rtl/arvi_mem_pkg.sv
// Shared definitions for the instruction-memory responder: FSM states,
// the error word and the address range check.
package arvi_mem_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;
  localparam logic [31:0] ERR_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } imr_state_t;

  // Operands are zero-extended to 64 bits so the word-count comparison cannot wrap.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input logic [63:0] depth_words);
    logic ok_s;
    ok_s = 1'b0;
    if (addr >= base) begin
      ok_s = (((addr - base) >> 2) < depth_words);
    end else begin
      ok_s = 1'b0;
    end
    return ok_s;
  endfunction

endpackage

// File: rtl/im_ram.sv
// Word RAM behind the responder: one synchronous write port and one
// synchronous read port, no reset on the array or the read register.
module im_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic            i_re,
  input  logic [AW-1:0]   i_raddr,
  output logic [XLEN-1:0] o_rdata
);

  logic [XLEN-1:0] mem_r [DEPTH];
  logic [XLEN-1:0] rdata_r;

  // Write port
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_r[i_waddr] <= i_wdata;
    end
  end

  // Read port: a same-edge write to the same index returns the old word
  always_ff @(posedge i_clk) begin
    if (i_re) begin
      rdata_r <= mem_r[i_raddr];
    end
  end

  assign o_rdata = rdata_r;

endmodule

// File: rtl/im_responder.sv
// Instruction-fetch refill responder: accepts a level request, waits LATENCY
// edges, then returns one word with a single-cycle ready pulse.
module im_responder
  import arvi_mem_pkg::*;
#(
  parameter int unsigned     DEPTH     = 1024,
  parameter int unsigned     LATENCY   = 2,
  parameter int unsigned     XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] BASE_ADDR = XLEN'(PC_RESET)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_DataReq,
  input  logic [XLEN-1:0]          i_MemAddr,
  output logic [XLEN-1:0]          o_DataBlock,
  output logic                     o_MemReady,
  output logic                     o_err,
  output logic                     o_busy,
  input  logic                     i_ld_en,
  input  logic [$clog2(DEPTH)-1:0] i_ld_idx,
  input  logic [XLEN-1:0]          i_ld_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  imr_state_t      state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [XLEN-1:0] addr_r, addr_s;
  logic            ready_r, ready_s;
  logic            resp_err_r, resp_err_s;
  logic            valid_r, valid_s;
  logic            rd_en_s;
  logic            in_range_s;
  logic [AW-1:0]   rd_idx_s;
  logic [XLEN-1:0] ram_q_s;

  assign in_range_s = addr_in_range(64'(addr_r), 64'(BASE_ADDR), 64'(DEPTH));
  assign rd_idx_s   = AW'((addr_r - BASE_ADDR) >> 2);

  im_ram #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN),
    .AW    (AW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (i_ld_en),
    .i_waddr (i_ld_idx),
    .i_wdata (i_ld_data),
    .i_re    (rd_en_s),
    .i_raddr (rd_idx_s),
    .o_rdata (ram_q_s)
  );

  // Next-state, counter, address latch and response flags
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    addr_s     = addr_r;
    ready_s    = 1'b0;
    resp_err_s = resp_err_r;
    valid_s    = valid_r;
    rd_en_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_DataReq) begin
          addr_s  = i_MemAddr;
          cnt_s   = CW'(LATENCY - 1);
          state_s = WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == '0) begin
          rd_en_s    = 1'b1;
          ready_s    = 1'b1;
          resp_err_s = ~in_range_s;
          valid_s    = 1'b1;
          state_s    = DONE;
        end else begin
          cnt_s = cnt_r - CW'(1);
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and response registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      addr_r     <= '0;
      ready_r    <= 1'b0;
      resp_err_r <= 1'b0;
      valid_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      addr_r     <= addr_s;
      ready_r    <= ready_s;
      resp_err_r <= resp_err_s;
      valid_r    <= valid_s;
    end
  end

  // The unreset RAM read register is masked until the first in-range response
  assign o_DataBlock = (valid_r && !resp_err_r) ? ram_q_s : XLEN'(ERR_WORD);
  assign o_MemReady  = ready_r;
  assign o_err       = ready_r & resp_err_r;
  assign o_busy      = (state_r != IDLE);

endmodule

// File: tb/tb_im_responder.sv
// Bench for im_responder: two instances (LATENCY 2 and 1) checked every cycle
// against a cycle-count model, plus directed literal expectations.
module tb_im_responder;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [2];
  logic [31:0] addr  [2];
  logic [31:0] dat   [2];
  logic        rdy   [2];
  logic        er    [2];
  logic        bsy   [2];
  logic        ld_en;
  logic [3:0]  ld_idx;
  logic [31:0] ld_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  im_responder #(.DEPTH(DEPTH), .LATENCY(2), .XLEN(32), .BASE_ADDR(BASE)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_DataReq(req[0]), .i_MemAddr(addr[0]),
    .o_DataBlock(dat[0]), .o_MemReady(rdy[0]), .o_err(er[0]), .o_busy(bsy[0]),
    .i_ld_en(ld_en), .i_ld_idx(ld_idx), .i_ld_data(ld_data));

  im_responder #(.DEPTH(DEPTH), .LATENCY(1), .XLEN(32), .BASE_ADDR(BASE)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_DataReq(req[1]), .i_MemAddr(addr[1]),
    .o_DataBlock(dat[1]), .o_MemReady(rdy[1]), .o_err(er[1]), .o_busy(bsy[1]),
    .i_ld_en(ld_en), .i_ld_idx(ld_idx), .i_ld_data(ld_data));

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %h expected %h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Model: a request is accepted on an edge when not pending and past the
  // turnaround edge; it is answered exactly LATENCY edges later.
  int          cyc = 0;
  int          lat_m  [2] = '{2, 1};
  bit          pend_m [2] = '{1'b0, 1'b0};
  int          due_m  [2] = '{0, 0};
  int          free_m [2] = '{-1, -1};
  logic [31:0] maddr_m[2] = '{32'h0, 32'h0};
  logic        exp_rdy[2] = '{1'b0, 1'b0};
  logic        exp_err[2] = '{1'b0, 1'b0};
  logic        exp_bsy[2] = '{1'b0, 1'b0};
  logic [31:0] exp_dat[2] = '{32'h0, 32'h0};
  logic [31:0] mem_m  [DEPTH];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst === 1'b1) begin
      for (int i = 0; i < 2; i++) begin
        exp_rdy[i] = 1'b0;
        exp_err[i] = 1'b0;
        if (pend_m[i] && cyc == due_m[i]) begin
          if (maddr_m[i] >= BASE && (maddr_m[i] - BASE) < 32'd64) begin
            exp_dat[i] = mem_m[(maddr_m[i] - BASE) / 32'd4];
          end else begin
            exp_dat[i] = 32'h0;
            exp_err[i] = 1'b1;
          end
          exp_rdy[i] = 1'b1;
          pend_m[i]  = 1'b0;
          free_m[i]  = cyc + 1;
        end else if (!pend_m[i] && cyc > free_m[i] && req[i]) begin
          pend_m[i]  = 1'b1;
          due_m[i]   = cyc + lat_m[i];
          maddr_m[i] = addr[i];
        end
        exp_bsy[i] = pend_m[i] || exp_rdy[i];
      end
    end
    if (ld_en) mem_m[ld_idx] = ld_data;
  end

  always @(negedge rst) begin
    for (int i = 0; i < 2; i++) begin
      pend_m[i]  = 1'b0;
      free_m[i]  = -1;
      exp_rdy[i] = 1'b0;
      exp_err[i] = 1'b0;
      exp_bsy[i] = 1'b0;
      exp_dat[i] = 32'h0;
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("ready", i, {31'h0, rdy[i]}, {31'h0, exp_rdy[i]});
      chk("err",   i, {31'h0, er[i]},  {31'h0, exp_err[i]});
      chk("busy",  i, {31'h0, bsy[i]}, {31'h0, exp_bsy[i]});
      chk("data",  i, dat[i], exp_dat[i]);
    end
  end

  task automatic load(input int idx, input logic [31:0] d);
    ld_en = 1'b1; ld_idx = 4'(idx); ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic do_req(input int i, input logic [31:0] a, input logic [31:0] alt,
                        output logic [31:0] d, output logic e, output int n);
    req[i] = 1'b1; addr[i] = a;
    @(negedge clk);
    req[i] = 1'b0; addr[i] = alt; n = 1;
    while (rdy[i] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    d = dat[i]; e = er[i];
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          n;
    int          pos[$];
    int          cnt;
    rst = 1'b0; ld_en = 1'b0; ld_idx = 4'h0; ld_data = 32'h0;
    for (int i = 0; i < 2; i++) begin req[i] = 1'b0; addr[i] = 32'h0; end
    repeat (3) @(negedge clk);
    chk("rst_data", 0, dat[0], 32'h0);
    chk("rst_busy", 1, {31'h0, bsy[1]}, 32'h0);
    rst = 1'b1;
    for (int k = 0; k < DEPTH; k++) load(k, 32'h1000_0000 + 32'(k));
    load(0, 32'h0000_0013);
    load(1, 32'h00A0_0093);

    do_req(0, BASE, BASE, d, e, n);
    chk("t1_lat", 0, 32'(n), 32'd3);
    chk("t1_data", 0, d, 32'h0000_0013);
    chk("t1_err", 0, {31'h0, e}, 32'h0);
    do_req(1, BASE, BASE, d, e, n);
    chk("t1_lat", 1, 32'(n), 32'd2);
    chk("t1_data", 1, d, 32'h0000_0013);

    // Held request: served every LATENCY+2 cycles
    req[0] = 1'b1; addr[0] = BASE + 32'd4;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (rdy[0]) begin
        pos.push_back(k);
        chk("t2_data", 0, dat[0], 32'h00A0_0093);
      end
    end
    req[0] = 1'b0;
    chk("t2_pulses", 0, 32'(pos.size()), 32'd3);
    if (pos.size() == 3) begin
      chk("t2_first", 0, 32'(pos[0]), 32'd3);
      chk("t2_gap1", 0, 32'(pos[1] - pos[0]), 32'd4);
      chk("t2_gap2", 0, 32'(pos[2] - pos[1]), 32'd4);
    end
    repeat (2) @(negedge clk);

    do_req(0, BASE - 32'd4, BASE - 32'd4, d, e, n);
    chk("t3_lo_data", 0, d, 32'h0);
    chk("t3_lo_err", 0, {31'h0, e}, 32'h1);
    do_req(0, BASE + 32'd60, BASE + 32'd60, d, e, n);
    chk("t3_last_data", 0, d, 32'h1000_000F);
    chk("t3_last_err", 0, {31'h0, e}, 32'h0);
    do_req(0, BASE + 32'd64, BASE + 32'd64, d, e, n);
    chk("t3_hi_data", 0, d, 32'h0);
    chk("t3_hi_err", 0, {31'h0, e}, 32'h1);
    do_req(1, BASE + 32'd5, BASE + 32'd5, d, e, n);
    chk("t3_lowbits", 1, d, 32'h00A0_0093);

    do_req(0, BASE, BASE + 32'd4, d, e, n);
    chk("t4_latched", 0, d, 32'h0000_0013);

    // Load on the response edge returns the old word
    req[0] = 1'b1; addr[0] = BASE;
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    ld_en = 1'b1; ld_idx = 4'h0; ld_data = 32'hDEAD_BEEF;
    @(negedge clk);
    ld_en = 1'b0;
    chk("t5_ready", 0, {31'h0, rdy[0]}, 32'h1);
    chk("t5_old", 0, dat[0], 32'h0000_0013);
    @(negedge clk);
    do_req(0, BASE, BASE, d, e, n);
    chk("t5_new", 0, d, 32'hDEAD_BEEF);

    // Asynchronous reset while both instances are in WAIT
    req[0] = 1'b1; addr[0] = BASE + 32'd4;
    req[1] = 1'b1; addr[1] = BASE + 32'd4;
    @(negedge clk);
    req[0] = 1'b0; req[1] = 1'b0;
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("t6_data", i, dat[i], 32'h0);
      chk("t6_ready", i, {31'h0, rdy[i]}, 32'h0);
      chk("t6_err", i, {31'h0, er[i]}, 32'h0);
      chk("t6_busy", i, {31'h0, bsy[i]}, 32'h0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rdy[0] || rdy[1]) cnt++;
    end
    chk("t6_no_pulse", 0, 32'(cnt), 32'd0);
    do_req(0, BASE + 32'd4, BASE + 32'd4, d, e, n);
    chk("t6_lat", 0, 32'(n), 32'd3);
    chk("t6_data_after", 0, d, 32'h00A0_0093);
    do_req(1, BASE + 32'd4, BASE + 32'd4, d, e, n);
    chk("t6_lat", 1, 32'(n), 32'd2);
    chk("t6_data_after", 1, d, 32'h00A0_0093);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/im_responder.md
# im_responder

Memory-side responder for the instruction-fetch refill interface driven by `i_cache` inside `datapath_sc`. It accepts the cache's level request (`o_DataReq`/`o_MemAddr`) and returns one 32-bit instruction word with a single-cycle ready pulse after a programmable latency. Data comes from an internal word RAM, which a side load port can fill (bootloader/testbench). The block sits at the top level, between the core's `o_IC_DataReq`/`o_IM_Addr` and `i_IM_Instr`/`i_IC_MemReady`.

## Interface
Parameters:
- `DEPTH`, 1024: RAM size in 32-bit words; power of two.
- `LATENCY`, 2: edges from request acceptance to `o_MemReady` high; must be ≥1.
- `BASE_ADDR`, `` `PC_RESET ``: byte address of word 0; word-aligned.
- `XLEN`, `` `XLEN `` (32): data/address width.

Ports:
- `i_clk` in 1: the single clock. Reset is asynchronous and active-low.
- `i_rst` in 1: active-low asynchronous reset.
- `i_DataReq` in 1: level request from the cache.
- `i_MemAddr` in XLEN: byte address of the request.
- `o_DataBlock` out XLEN: returned word; registered.
- `o_MemReady` out 1: one-cycle pulse, data valid.
- `o_err` out 1: pulses with `o_MemReady` when the address is out of range.
- `o_busy` out 1: high when state ≠ IDLE.
- `i_ld_en` in 1: RAM load strobe.
- `i_ld_idx` in $clog2(DEPTH): word index to load.
- `i_ld_data` in XLEN: load data.

## Operation
- FSM states:
  - IDLE: when `i_DataReq`=1, latch `i_MemAddr`, load `cnt`←LATENCY-1, go to WAIT.
  - WAIT: if `cnt`==0, register `o_DataBlock`, set `o_MemReady`=1 and `o_err` as computed, go to DONE. Otherwise decrement `cnt`.
  - DONE: the ready cycle. `i_DataReq` is ignored. Unconditionally go to IDLE; `o_MemReady`/`o_err` return to 0.
- Address decode on the latched address:
  - `idx = (addr - BASE_ADDR) >> 2`; bits [1:0] are ignored.
  - Out of range when `addr < BASE_ADDR` or `idx ≥ DEPTH`. In that case the returned word is `ERR_WORD` (32'h0000_0000) and `o_err`=1.
- Load port:
  - Writes the RAM on any edge with `i_ld_en`=1, independent of FSM state.
  - A load at edge k is visible to a response registered at edge ≥ k+1.
  - A load and a response read of the same index on the same edge return the old word.
- `i_DataReq` and `i_MemAddr` changes during WAIT/DONE are ignored. The latched address is authoritative.
- `cnt` width is $clog2(LATENCY+1). It never underflows.

## Timing
- Reset (`i_rst`=0, asynchronous):
  - state←IDLE, `cnt`←0, latched address←0.
  - `o_DataBlock`←0, `o_MemReady`←0, `o_err`←0, `o_busy`←0.
  - RAM contents are not reset.
- Reset mid-WAIT/DONE drops the pending request with no ready pulse. The cache must re-request.
- Request accepted at edge E0 → `o_MemReady` high during the cycle after edge E0+LATENCY, for exactly one cycle.
- `o_DataBlock` holds its last value until the next response.
- A request held continuously is served once per LATENCY+2 cycles. This is the minimum request-to-request spacing.
- `o_busy` is high from the cycle after E0 through the DONE cycle inclusive.

## Structure
- Shared package `arvi_mem_pkg`:
  - state enum `imr_state_t` {IDLE, WAIT, DONE}.
  - `ERR_WORD` constant.
  - helper function for the in-range check.
- Sub-module `im_ram`: DEPTH×XLEN, one synchronous write port and one synchronous read port, no reset. The read enable is the WAIT&&`cnt`==0 condition.
- Expected size: ~150–200 lines of RTL including `im_ram`.

## Test plan
- Reset, then load idx 0 = 32'h0000_0013 and idx 1 = 32'h00A0_0093. Request `BASE_ADDR`, LATENCY=2 → ready pulse 2 edges after acceptance with data 32'h0000_0013, `o_err`=0.
- Hold `i_DataReq` high at `BASE_ADDR+4` for 12 cycles, LATENCY=2 → exactly 3 ready pulses, 4 cycles apart, each with 32'h00A0_0093.
- Request `BASE_ADDR-4`, then `BASE_ADDR+4*DEPTH` → each returns 32'h0, `o_err`=1 coincident with `o_MemReady`.
- Change `i_MemAddr` from `BASE_ADDR` to `BASE_ADDR+4` during WAIT → response is word 0.
- Load idx 0 with 32'hDEAD_BEEF on the response edge → old word returned. Re-request → 32'hDEAD_BEEF.
- Assert `i_rst`=0 asynchronously mid-WAIT → all outputs 0 immediately and no ready pulse. After release, a new request completes normally. Repeat with LATENCY=1: ready appears on the first edge after acceptance.
